// File: rtl/cr16_uart_loader.sv
// UART program loader for the CR16 BRAM: receives a framed image on
// I_UART_RX and writes it word-by-word into BRAM port B, holding the core off.
//
// Ports:
//   I_CLK, I_NRESET     system clock, asynchronous active-low reset
//   I_UART_RX           8N1 serial line, idles high, LSB first
//   O_MEM_ADDRESS       port-B write address
//   O_MEM_DATA          port-B write data {hi, lo}
//   O_MEM_WRITE_ENABLE  one-cycle write strobe
//   O_CPU_HOLD          core must be disabled while high
//   O_DONE, O_ERROR     result of the last frame (levels)
module cr16_uart_loader #(
  parameter int          P_CLKS_PER_BIT  = 434,
  parameter int          P_ADDRESS_WIDTH = 10,
  parameter int          P_DATA_WIDTH    = 16,
  parameter logic [7:0]  P_SYNC_BYTE     = 8'hA5
) (
  input  logic                       I_CLK,
  input  logic                       I_NRESET,
  input  logic                       I_UART_RX,
  output logic [P_ADDRESS_WIDTH-1:0] O_MEM_ADDRESS,
  output logic [P_DATA_WIDTH-1:0]    O_MEM_DATA,
  output logic                       O_MEM_WRITE_ENABLE,
  output logic                       O_CPU_HOLD,
  output logic                       O_DONE,
  output logic                       O_ERROR
);

  localparam int LP_CW = $clog2(P_CLKS_PER_BIT);
  localparam logic [LP_CW-1:0] LP_FULL =
    LP_CW'(P_CLKS_PER_BIT - 1);
  localparam logic [LP_CW-1:0] LP_HALF =
    LP_CW'(P_CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0] LP_MAX_WORDS =
    17'(1) << P_ADDRESS_WIDTH;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    F_IDLE, F_LEN_HI, F_LEN_LO,
    F_DATA_HI, F_DATA_LO, F_CHECK
  } f_state_t;

  logic             r_rx_meta;
  logic             r_rx_sync;
  logic             r_rx_prev;
  rx_state_t        r_rx_state;
  logic [LP_CW-1:0] r_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_byte_valid;
  logic [7:0]       r_byte;
  logic             r_framing_err;

  f_state_t                  r_f_state;
  logic [7:0]                r_len_hi;
  logic [7:0]                r_data_hi;
  logic [15:0]               r_words_left;
  logic [7:0]                r_csum;
  logic [P_ADDRESS_WIDTH-1:0] r_addr;
  logic                      r_addr_inc;
  logic [P_ADDRESS_WIDTH-1:0] r_mem_addr;
  logic [P_DATA_WIDTH-1:0]    r_mem_data;
  logic                      r_mem_we;
  logic                      r_hold;
  logic                      r_done;
  logic                      r_error;

  logic [15:0] w_len;
  logic [7:0]  w_csum_next;

  assign w_len       = {r_len_hi, r_byte};
  assign w_csum_next = r_csum ^ r_byte;

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= I_UART_RX;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      r_rx_state    <= RX_IDLE;
      r_cnt         <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_byte_valid  <= 1'b0;
      r_byte        <= '0;
      r_framing_err <= 1'b0;
    end else begin
      r_byte_valid  <= 1'b0;
      r_framing_err <= 1'b0;
      unique case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_prev && !r_rx_sync) begin
            r_rx_state <= RX_START;
            r_cnt      <= '0;
          end
        end
        RX_START: begin
          if (r_cnt == LP_HALF) begin
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + LP_CW'(1);
          end
        end
        RX_DATA: begin
          if (r_cnt == LP_FULL) begin
            r_cnt     <= '0;
            r_shift   <= {r_rx_sync, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_rx_state <= RX_STOP;
          end else begin
            r_cnt <= r_cnt + LP_CW'(1);
          end
        end
        RX_STOP: begin
          if (r_cnt == LP_FULL) begin
            r_cnt      <= '0;
            r_rx_state <= RX_IDLE;
            if (r_rx_sync) begin
              r_byte_valid <= 1'b1;
              r_byte       <= r_shift;
            end else begin
              r_framing_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + LP_CW'(1);
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      r_f_state    <= F_IDLE;
      r_len_hi     <= '0;
      r_data_hi    <= '0;
      r_words_left <= '0;
      r_csum       <= '0;
      r_addr       <= '0;
      r_addr_inc   <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_mem_we     <= 1'b0;
      r_hold       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_mem_we   <= 1'b0;
      r_addr_inc <= 1'b0;
      // Address advances the cycle after its strobe.
      if (r_addr_inc) r_addr <= r_addr + P_ADDRESS_WIDTH'(1);
      if (r_framing_err && r_f_state != F_IDLE) begin
        r_error   <= 1'b1;
        r_f_state <= F_IDLE;
      end else if (r_byte_valid) begin
        unique case (r_f_state)
          F_IDLE: begin
            if (r_byte == P_SYNC_BYTE) begin
              r_done    <= 1'b0;
              r_error   <= 1'b0;
              r_hold    <= 1'b1;
              r_addr    <= '0;
              r_csum    <= '0;
              r_f_state <= F_LEN_HI;
            end
          end
          F_LEN_HI: begin
            r_len_hi  <= r_byte;
            r_csum    <= w_csum_next;
            r_f_state <= F_LEN_LO;
          end
          F_LEN_LO: begin
            r_csum       <= w_csum_next;
            r_words_left <= w_len;
            if ({1'b0, w_len} > LP_MAX_WORDS) begin
              r_error   <= 1'b1;
              r_f_state <= F_IDLE;
            end else if (w_len == 16'd0) begin
              r_f_state <= F_CHECK;
            end else begin
              r_f_state <= F_DATA_HI;
            end
          end
          F_DATA_HI: begin
            r_data_hi <= r_byte;
            r_csum    <= w_csum_next;
            r_f_state <= F_DATA_LO;
          end
          F_DATA_LO: begin
            r_csum       <= w_csum_next;
            r_mem_data   <= {r_data_hi, r_byte};
            r_mem_addr   <= r_addr;
            r_mem_we     <= 1'b1;
            r_addr_inc   <= 1'b1;
            r_words_left <= r_words_left - 16'd1;
            r_f_state    <= (r_words_left == 16'd1) ?
                            F_CHECK : F_DATA_HI;
          end
          F_CHECK: begin
            if (r_byte == r_csum) begin
              r_done <= 1'b1;
              r_hold <= 1'b0;
            end else begin
              r_error <= 1'b1;
            end
            r_f_state <= F_IDLE;
          end
          default: r_f_state <= F_IDLE;
        endcase
      end
    end
  end

  assign O_MEM_ADDRESS      = r_mem_addr;
  assign O_MEM_DATA         = r_mem_data;
  assign O_MEM_WRITE_ENABLE = r_mem_we;
  assign O_CPU_HOLD         = r_hold;
  assign O_DONE             = r_done;
  assign O_ERROR            = r_error;

endmodule

// File: tb/tb_cr16_uart_loader.sv
// Bench for cr16_uart_loader: directed and randomized frames against
// a byte-level frame model; strobes and status checked every settled cycle.
module tb_cr16_uart_loader;

  localparam int CPB = 16;
  localparam int AW  = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_data;
  logic          mem_we;
  logic          hold;
  logic          done;
  logic          err;

  cr16_uart_loader #(
    .P_CLKS_PER_BIT (CPB),
    .P_ADDRESS_WIDTH(AW),
    .P_DATA_WIDTH   (16),
    .P_SYNC_BYTE    (8'hA5)
  ) dut (
    .I_CLK             (clk),
    .I_NRESET          (rst_n),
    .I_UART_RX         (rx),
    .O_MEM_ADDRESS     (mem_addr),
    .O_MEM_DATA        (mem_data),
    .O_MEM_WRITE_ENABLE(mem_we),
    .O_CPU_HOLD        (hold),
    .O_DONE            (done),
    .O_ERROR           (err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model state: bytes of the current frame after sync.
  bit          in_frame;
  logic [7:0]  fb[$];
  int          n_words;
  logic        m_done, m_err, m_hold;
  logic [25:0] q_exp[$];
  logic [25:0] q_got[$];
  logic [25:0] last_wr;
  int          nwr = 0;
  bit          settled = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp,
               $time);
    end
  endtask

  function automatic void model_reset();
    in_frame = 0;
    fb.delete();
    m_done = 0;
    m_err  = 0;
    m_hold = 0;
    q_exp.delete();
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int k;
    logic [7:0] x;
    if (!in_frame) begin
      if (b == 8'hA5) begin
        in_frame = 1;
        fb.delete();
        m_done = 0;
        m_err  = 0;
        m_hold = 1;
      end
      return;
    end
    fb.push_back(b);
    k = fb.size();
    if (k == 1) return;
    if (k == 2) begin
      n_words = {fb[0], fb[1]};
      if (n_words > (1 << AW)) begin
        m_err = 1;
        in_frame = 0;
      end
      return;
    end
    if (k <= 2 + 2 * n_words) begin
      if (k % 2 == 0)
        q_exp.push_back({AW'((k - 4) / 2), fb[k-2], fb[k-1]});
      return;
    end
    x = 8'h00;
    for (int i = 0; i < k - 1; i++) x ^= fb[i];
    if (x == b) begin
      m_done = 1;
      m_hold = 0;
    end else begin
      m_err = 1;
    end
    in_frame = 0;
  endfunction

  function automatic void model_ferr();
    if (in_frame) begin
      m_err = 1;
      in_frame = 0;
    end
  endfunction

  always @(negedge clk) begin
    logic [25:0] g, e;
    if (mem_we) begin
      q_got.push_back({mem_addr, mem_data});
      last_wr = {mem_addr, mem_data};
      nwr++;
    end
    if (settled) begin
      chk("done", 32'(done), 32'(m_done));
      chk("error", 32'(err), 32'(m_err));
      chk("hold", 32'(hold), 32'(m_hold));
      while (q_got.size() > 0 && q_exp.size() > 0) begin
        g = q_got.pop_front();
        e = q_exp.pop_front();
        chk("write", 32'(g), 32'(e));
      end
      if (q_got.size() > 0) begin
        chk("unexpected_strobe", 32'(q_got[0]), 32'hFFFF_FFFF);
        q_got.delete();
      end
      if (q_exp.size() > 0) begin
        chk("missing_strobe", 32'hFFFF_FFFF, 32'(q_exp[0]));
        q_exp.delete();
      end
    end
  end

  task automatic send_byte(input logic [7:0] b,
                           input bit bad_stop = 0);
    settled = 0;
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    rx = bad_stop ? 1'b0 : 1'b1;
    repeat (CPB) @(posedge clk);
    rx = 1'b1;
    if (bad_stop) model_ferr();
    else          model_byte(b);
    settled = 1;
  endtask

  task automatic send_list(input logic [7:0] bl[$]);
    foreach (bl[i]) send_byte(bl[i]);
  endtask

  task automatic send_frame(input int n, input bit corrupt);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'(n >> 8) ^ 8'(n);
    send_byte(8'hA5);
    send_byte(8'(n >> 8));
    repeat ($urandom_range(0, 12)) @(posedge clk);
    send_byte(8'(n));
    for (int i = 0; i < 2 * n; i++) begin
      b = 8'($urandom);
      x ^= b;
      send_byte(b);
      repeat ($urandom_range(0, 12)) @(posedge clk);
    end
    send_byte(corrupt ? ~x : x);
  endtask

  task automatic do_reset(input int cycles);
    settled = 0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    repeat (cycles) @(negedge clk);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_data", 32'(mem_data), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_hold", 32'(hold), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(err), 32'd0);
    q_got.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    settled = 1;
  endtask

  initial begin
    int w0;
    logic [7:0] g;
    rst_n = 1'b0;
    rx    = 1'b1;
    model_reset();
    // 1: reset, idle line, no strobes
    do_reset(5);
    repeat (2000) @(posedge clk);
    chk("t1_nwr", 32'(nwr), 32'd0);

    // 2: good two-word frame
    w0 = nwr;
    send_list('{8'hA5});
    chk("t2_hold_after_sync", 32'(hold), 32'd1);
    send_list('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD});
    chk("t2_hold_before_csum", 32'(hold), 32'd1);
    send_list('{8'h42});
    repeat (4) @(posedge clk);
    chk("t2_nwr", 32'(nwr - w0), 32'd2);
    chk("t2_last_wr", 32'(last_wr), 32'({10'd1, 16'hABCD}));
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_hold", 32'(hold), 32'd0);

    // 3: bad checksum, then a good frame
    w0 = nwr;
    send_list('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34,
                8'hAB, 8'hCD, 8'h43});
    repeat (4) @(posedge clk);
    chk("t3_nwr", 32'(nwr - w0), 32'd2);
    chk("t3_error", 32'(err), 32'd1);
    chk("t3_hold", 32'(hold), 32'd1);
    send_frame(1, 0);
    repeat (4) @(posedge clk);
    chk("t3_recover_done", 32'(done), 32'd1);

    // 4: leading garbage, zero-length frame
    w0 = nwr;
    send_list('{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00});
    repeat (4) @(posedge clk);
    chk("t4_nwr", 32'(nwr - w0), 32'd0);
    chk("t4_done", 32'(done), 32'd1);

    // 5: oversized length
    w0 = nwr;
    send_list('{8'hA5, 8'h04, 8'h01});
    chk("t5_error", 32'(err), 32'd1);
    send_list('{8'h12, 8'h34});
    repeat (4) @(posedge clk);
    chk("t5_nwr", 32'(nwr - w0), 32'd0);

    // 6a: 5-cycle low glitch
    repeat (20) @(posedge clk);
    rx = 1'b0;
    repeat (5) @(posedge clk);
    rx = 1'b1;
    repeat (300) @(posedge clk);
    send_frame(0, 0);
    chk("t6a_done", 32'(done), 32'd1);

    // 6b: framing error mid-frame
    send_list('{8'hA5, 8'h00, 8'h02, 8'h12});
    send_byte(8'h34, 1);
    repeat (4) @(posedge clk);
    chk("t6b_error", 32'(err), 32'd1);
    chk("t6b_hold", 32'(hold), 32'd1);

    // 6c: reset between data bytes, then reload from 0
    send_list('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34});
    repeat (3) @(posedge clk);
    do_reset(3);
    repeat (10) @(posedge clk);
    send_list('{8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'h50});
    repeat (4) @(posedge clk);
    chk("t6c_wr", 32'(last_wr), 32'({10'd0, 16'hBEEF}));
    chk("t6c_done", 32'(done), 32'd1);

    // Randomized frames with garbage and corruption
    for (int f = 0; f < 14; f++) begin
      repeat ($urandom_range(0, 2)) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h5A;
        send_byte(g);
      end
      send_frame($urandom_range(0, 5), ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(2, 40)) @(posedge clk);
    end

    repeat (20) @(posedge clk);
    settled = 0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
